// File: rtl/dispense_collector.sv
// dispense_collector
//   Customer-side receiver for the vending datapath's ticket and one-unit
//   change-coin pulse trains. Rising edges on each line are counted. A burst
//   closes after IDLE_CYC consecutive cycles with no edge on either line, and
//   the resulting {tickets, change} record is then offered on a valid/ready
//   handshake.
//
// Ports
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   ticket_pulse   ticket pulse train, one rising edge per ticket
//   coin_one_pulse change pulse train, one rising edge per one-unit coin
//   rec_valid      record available, held until accepted
//   rec_ready      consumer accepts the record when rec_valid & rec_ready
//   rec_tickets    tickets counted in the closed burst
//   rec_change     change coins counted in the closed burst
//   rec_sat        a count field saturated during this burst
//   lost           sticky flag: an edge arrived while a record was held
//   busy           high while collecting or holding a record
module dispense_collector #(
  parameter int DW       = 8,
  parameter int IDLE_CYC = 16,
  parameter int TW       = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ticket_pulse,
  input  logic          coin_one_pulse,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [DW-1:0] rec_tickets,
  output logic [DW-1:0] rec_change,
  output logic          rec_sat,
  output logic          lost,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t        state;
  logic          tp_q;
  logic          cp_q;
  logic [DW-1:0] tickets;
  logic [DW-1:0] change;
  logic [TW-1:0] gap;
  logic          sat_q;
  logic          lost_q;
  logic          valid_q;
  logic          busy_q;

  logic          t_edge;
  logic          c_edge;
  logic          any_edge;
  logic [DW:0]   t_inc;
  logic [DW:0]   c_inc;

  // Saturating increment: returns {hit_ceiling, next_value}. The ceiling flag
  // is raised only when an increment is requested on a full count.
  function automatic logic [DW:0] sat_inc(input logic [DW-1:0] v, input logic inc);
    logic [DW:0] r;
    if (!inc)
      r = {1'b0, v};
    else if (&v)
      r = {1'b1, v};
    else
      r = {1'b0, v + DW'(1)};
    return r;
  endfunction

  assign t_edge   = ticket_pulse & ~tp_q;
  assign c_edge   = coin_one_pulse & ~cp_q;
  assign any_edge = t_edge | c_edge;

  always_comb begin
    t_inc = sat_inc(tickets, t_edge);
    c_inc = sat_inc(change, c_edge);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tp_q    <= 1'b0;
      cp_q    <= 1'b0;
      tickets <= '0;
      change  <= '0;
      gap     <= '0;
      sat_q   <= 1'b0;
      lost_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tp_q <= ticket_pulse;
      cp_q <= coin_one_pulse;
      case (state)
        S_IDLE: begin
          // Counts are zero here, so the opening edge loads directly.
          tickets <= DW'(t_edge);
          change  <= DW'(c_edge);
          gap     <= '0;
          sat_q   <= 1'b0;
          valid_q <= 1'b0;
          if (any_edge) begin
            state  <= S_COLLECT;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end

        S_COLLECT: begin
          tickets <= t_inc[DW-1:0];
          change  <= c_inc[DW-1:0];
          if (t_inc[DW] | c_inc[DW])
            sat_q <= 1'b1;
          if (any_edge) begin
            gap <= '0;
          end else if (gap == TW'(IDLE_CYC - 1)) begin
            // IDLE_CYC edge-free cycles since the last edge: close the burst.
            gap     <= '0;
            state   <= S_HOLD;
            valid_q <= 1'b1;
          end else begin
            gap <= gap + TW'(1);
          end
        end

        S_HOLD: begin
          if (rec_ready) begin
            // An edge in the accept cycle opens the next burst instead of
            // being lost.
            tickets <= DW'(t_edge);
            change  <= DW'(c_edge);
            sat_q   <= 1'b0;
            gap     <= '0;
            valid_q <= 1'b0;
            if (any_edge) begin
              state <= S_COLLECT;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else if (any_edge) begin
            lost_q <= 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          tickets <= '0;
          change  <= '0;
          gap     <= '0;
          sat_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rec_valid   = valid_q;
  assign rec_tickets = tickets;
  assign rec_change  = change;
  assign rec_sat     = sat_q;
  assign lost        = lost_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dispense_collector.sv
module tb_dispense_collector;
  localparam int DW       = 8;
  localparam int IDLE_CYC = 16;
  localparam int TW       = 5;
  localparam int MAXC     = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ticket_pulse = 1'b0;
  logic          coin_one_pulse = 1'b0;
  logic          rec_ready = 1'b0;
  logic          rec_valid;
  logic [DW-1:0] rec_tickets;
  logic [DW-1:0] rec_change;
  logic          rec_sat;
  logic          lost;
  logic          busy;

  dispense_collector #(.DW(DW), .IDLE_CYC(IDLE_CYC), .TW(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ticket_pulse  (ticket_pulse),
    .coin_one_pulse(coin_one_pulse),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_tickets   (rec_tickets),
    .rec_change    (rec_change),
    .rec_sat       (rec_sat),
    .lost          (lost),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: unbounded edge totals per burst, time of last edge,
  // and whether a closed record is waiting. Outputs are derived from these.
  int m_t, m_c, m_cyc, m_last;
  bit m_act, m_hold, m_lost, m_tp, m_cp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_c = 0; m_cyc = 0; m_last = 0;
      m_act = 0; m_hold = 0; m_lost = 0; m_tp = 0; m_cp = 0;
    end else begin
      bit te, ce;
      te = ticket_pulse && !m_tp;
      ce = coin_one_pulse && !m_cp;
      m_tp = ticket_pulse;
      m_cp = coin_one_pulse;
      m_cyc++;
      if (m_hold) begin
        if (rec_ready) begin
          m_hold = 0;
          m_t = int'(te);
          m_c = int'(ce);
          m_act = te || ce;
          m_last = m_cyc;
        end else if (te || ce) begin
          m_lost = 1;
        end
      end else if (te || ce) begin
        m_act = 1;
        m_t += int'(te);
        m_c += int'(ce);
        m_last = m_cyc;
      end else if (m_act && (m_cyc - m_last == IDLE_CYC)) begin
        m_act = 0;
        m_hold = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid",   rec_valid,   m_hold);
      chk("busy",    busy,        m_act || m_hold);
      chk("tickets", rec_tickets, (m_t > MAXC) ? MAXC : m_t);
      chk("change",  rec_change,  (m_c > MAXC) ? MAXC : m_c);
      chk("sat",     rec_sat,     (m_t > MAXC) || (m_c > MAXC));
      chk("lost",    lost,        m_lost);
    end
  end

  // Log of accepted records plus valid rise time and high width.
  int rq_t[$], rq_c[$], rq_s[$];
  int rise_cyc = 0, vh = 0, last_vh = 0;
  bit pv = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      if (rec_valid && !pv) rise_cyc = cyc;
      if (rec_valid) vh++;
      if (!rec_valid && pv) begin
        last_vh = vh;
        vh = 0;
      end
      if (rec_valid && rec_ready) begin
        rq_t.push_back(int'(rec_tickets));
        rq_c.push_back(int'(rec_change));
        rq_s.push_back(int'(rec_sat));
      end
      pv = rec_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_t();
    ticket_pulse = 1'b1; step(1);
    ticket_pulse = 1'b0; step(1);
  endtask

  task automatic pulse_c();
    coin_one_pulse = 1'b1; step(1);
    coin_one_pulse = 1'b0; step(1);
  endtask

  task automatic check_rec(input string name, input int t, input int c, input int s);
    if (rq_t.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no record accepted, expected t=%0d c=%0d s=%0d", name, t, c, s);
    end else begin
      chk({name, "_t"}, rq_t.pop_front(), t);
      chk({name, "_c"}, rq_c.pop_front(), c);
      chk({name, "_s"}, rq_s.pop_front(), s);
    end
  endtask

  int dcyc;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid",   rec_valid,   0);
    chk("rst_busy",    busy,        0);
    chk("rst_tickets", rec_tickets, 0);
    chk("rst_lost",    lost,        0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    started = 1'b1;
    step(1);

    // 1: mixed pulses, 2-cycle spacing
    rec_ready = 1'b1;
    pulse_t(); pulse_c(); pulse_t(); pulse_c();
    ticket_pulse = 1'b1; dcyc = cyc; step(1);
    ticket_pulse = 1'b0; step(1);
    step(25);
    check_rec("t1", 3, 2, 0);
    chk("t1_latency", rise_cyc - dcyc, 17);
    chk("t1_vwidth", last_vh, 1);

    // 2: simultaneous edges, then a long level
    repeat (4) begin
      ticket_pulse = 1'b1; coin_one_pulse = 1'b1; step(1);
      ticket_pulse = 1'b0; coin_one_pulse = 1'b0; step(1);
    end
    step(25);
    check_rec("t2a", 4, 4, 0);
    ticket_pulse = 1'b1; step(10);
    ticket_pulse = 1'b0; step(25);
    check_rec("t2b", 1, 0, 0);

    // 3: saturation and recovery
    repeat (300) pulse_t();
    step(25);
    check_rec("t3a", 255, 0, 1);
    pulse_t();
    step(25);
    check_rec("t3b", 1, 0, 0);

    // 4: held record, dropped edge, edge in the accept cycle
    rec_ready = 1'b0;
    pulse_t(); pulse_t();
    step(75);
    chk("t4_held_valid", rec_valid, 1);
    chk("t4_lost_before", lost, 0);
    pulse_c();
    step(2);
    chk("t4_lost_after", lost, 1);
    chk("t4_held_t", rec_tickets, 2);
    chk("t4_held_c", rec_change, 0);
    rec_ready = 1'b1; ticket_pulse = 1'b1; step(1);
    ticket_pulse = 1'b0; step(25);
    check_rec("t4a", 2, 0, 0);
    check_rec("t4b", 1, 0, 0);
    chk("t4_lost_sticky", lost, 1);

    // 5: asynchronous reset mid-burst
    pulse_t(); pulse_t();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_valid",   rec_valid,   0);
    chk("t5_busy",    busy,        0);
    chk("t5_tickets", rec_tickets, 0);
    chk("t5_change",  rec_change,  0);
    chk("t5_sat",     rec_sat,     0);
    chk("t5_lost",    lost,        0);
    @(posedge clk);
    #4 rst_n = 1'b1;
    step(1);
    pulse_t();
    step(25);
    check_rec("t5", 1, 0, 0);

    // 6: gap of IDLE_CYC-1 idle cycles keeps the burst open
    pulse_t();
    step(IDLE_CYC - 2);
    pulse_c();
    step(25);
    check_rec("t6", 1, 1, 0);
    chk("q_empty", rq_t.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
